shot_controller: RTL and testbench



---
 rtl/shot_pkg.sv | 47 ++++
 rtl/shot_controller_if.sv | 28 ++
 rtl/edge_sync.sv | 29 ++
 rtl/shot_controller.sv | 131 +++++++++++++
 tb/tb_shot_controller.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shot_pkg.sv
// Shared types for the shot controller: FSM states, packed BCD score and latched shot geometry.
// bcd_add_sat adds one BCD digit to a four-digit score and clamps the result at 9999.
package shot_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        RESOLVE  = 3'd2,
        FLASH    = 3'd3,
        COOLDOWN = 3'd4,
        EMPTY    = 3'd5
    } shot_state_t;

    typedef logic [3:0][3:0] bcd4_t;

    typedef struct packed {
        logic [9:0] cx;
        logic [9:0] cy;
        logic [9:0] dx;
        logic [9:0] dy;
        logic [9:0] sx;
        logic [9:0] sy;
        logic       act;
    } shot_req_t;

    function automatic bcd4_t bcd_add_sat(input bcd4_t s, input logic [3:0] pts);
        bcd4_t      r;
        logic [4:0] sum;
        logic [3:0] c;
        r = s;
        c = pts;
        for (int i = 0; i < 4; i++) begin
            sum = {1'b0, s[i]} + {1'b0, c};
            if (sum > 5'd9) begin
                r[i] = 4'(sum - 5'd10);
                c    = 4'd1;
            end else begin
                r[i] = sum[3:0];
                c    = 4'd0;
            end
        end
        // A carry out of the thousands digit means the true sum passed 9999.
        if (c != 4'd0) r = {4{4'd9}};
        return r;
    endfunction

endpackage

// File: rtl/shot_controller_if.sv
// Geometry, control and scoring signals between the cursor/dog path and the shot controller.
// master drives cursor, dog box and round_start; slave returns hit/miss, shells, score, flash and state.
interface shot_controller_if;
    logic [9:0]  CursorX;
    logic [9:0]  CursorY;
    logic [9:0]  DogX;
    logic [9:0]  DogY;
    logic [9:0]  DogSizeX;
    logic [9:0]  DogSizeY;
    logic        dog_active;
    logic        round_start;
    logic        hit;
    logic        miss;
    logic [1:0]  shells_left;
    logic [15:0] score_bcd;
    logic        flash;
    logic [2:0]  state_o;

    modport master (
        output CursorX, CursorY, DogX, DogY, DogSizeX, DogSizeY, dog_active, round_start,
        input  hit, miss, shells_left, score_bcd, flash, state_o
    );

    modport slave (
        input  CursorX, CursorY, DogX, DogY, DogSizeX, DogSizeY, dog_active, round_start,
        output hit, miss, shells_left, score_bcd, flash, state_o
    );
endinterface

// File: rtl/edge_sync.sv
// Two-flop synchroniser with a registered one-cycle rising-edge pulse.
// Pulse appears 3 clk cycles after the raw edge; no backpressure, a held level never repeats the pulse.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);
    logic sync1_q, sync2_q, prev_q, pulse_q;
    logic pulse_d;

    assign pulse_d = sync2_q & ~prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/shot_controller.sv
// Shot trigger, hit test, shell count, saturating BCD score and frame-timed screen flash.
// hit/miss pulse 5 Clk after the raw button edge; clicks outside ARMED are dropped, not queued.
module shot_controller
    import shot_pkg::*;
#(
    parameter int SHELLS          = 3,
    parameter int FLASH_FRAMES    = 2,
    parameter int COOLDOWN_FRAMES = 10,
    parameter int HIT_POINTS      = 5
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk,
    input  logic [7:0]         MouseButtons,
    shot_controller_if.slave   bus
);
    logic        frame_tick, fire, hit_cond;
    logic        unused_buttons;
    logic [10:0] cx_w, cy_w, x_lo, y_lo, x_hi, y_hi;

    shot_state_t state_q, state_d;
    shot_req_t   shot_q, shot_d;
    bcd4_t       score_q, score_d;
    logic [1:0]  shells_q, shells_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        flash_q, flash_d, hit_q, hit_d, miss_q, miss_d;

    assign unused_buttons = ^MouseButtons[7:1];

    edge_sync u_frame_sync (.clk(Clk), .rst_n(Reset_n), .async_in(frame_clk),       .pulse(frame_tick));
    edge_sync u_btn_sync   (.clk(Clk), .rst_n(Reset_n), .async_in(MouseButtons[0]), .pulse(fire));

    // Box edges widened by one bit so DogX+DogSizeX cannot wrap past 1023.
    assign cx_w = {1'b0, shot_q.cx};
    assign cy_w = {1'b0, shot_q.cy};
    assign x_lo = {1'b0, shot_q.dx};
    assign y_lo = {1'b0, shot_q.dy};
    assign x_hi = {1'b0, shot_q.dx} + {1'b0, shot_q.sx};
    assign y_hi = {1'b0, shot_q.dy} + {1'b0, shot_q.sy};
    assign hit_cond = shot_q.act && (cx_w >= x_lo) && (cx_w < x_hi) && (cy_w >= y_lo) && (cy_w < y_hi);

    always_comb begin
        state_d  = state_q;
        shot_d   = shot_q;
        score_d  = score_q;
        shells_d = shells_q;
        cnt_d    = cnt_q;
        flash_d  = flash_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        case (state_q)
            ARMED: begin
                if (fire && shells_q != 2'd0) begin
                    shot_d   = '{cx: bus.CursorX, cy: bus.CursorY, dx: bus.DogX, dy: bus.DogY,
                                 sx: bus.DogSizeX, sy: bus.DogSizeY, act: bus.dog_active};
                    shells_d = shells_q - 2'd1;
                    state_d  = RESOLVE;
                end
            end
            RESOLVE: begin
                if (hit_cond) begin
                    hit_d   = 1'b1;
                    score_d = bcd_add_sat(score_q, 4'(HIT_POINTS));
                end else begin
                    miss_d  = 1'b1;
                end
                flash_d = 1'b1;
                cnt_d   = 8'(FLASH_FRAMES);
                state_d = FLASH;
            end
            FLASH: begin
                if (frame_tick) begin
                    if (cnt_q <= 8'd1) begin
                        flash_d = 1'b0;
                        cnt_d   = 8'(COOLDOWN_FRAMES);
                        state_d = COOLDOWN;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            COOLDOWN: begin
                if (frame_tick) begin
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = (shells_q != 2'd0) ? ARMED : EMPTY;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: ;
        endcase
        // A new round overrides control state but keeps any RESOLVE pulse and score update.
        if (bus.round_start) begin
            shells_d = 2'(SHELLS);
            state_d  = ARMED;
            flash_d  = 1'b0;
            cnt_d    = 8'd0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            shot_q   <= '0;
            score_q  <= '0;
            shells_q <= 2'd0;
            cnt_q    <= 8'd0;
            flash_q  <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shot_q   <= shot_d;
            score_q  <= score_d;
            shells_q <= shells_d;
            cnt_q    <= cnt_d;
            flash_q  <= flash_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    assign bus.hit         = hit_q;
    assign bus.miss        = miss_q;
    assign bus.shells_left = shells_q;
    assign bus.score_bcd   = score_q;
    assign bus.flash       = flash_q;
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_shot_controller.sv
// Bench for shot_controller: reset, timing, hit-test edges, shell/round handling and BCD saturation.
// Expected values come from an integer-arithmetic model of the scoring and hit rules.
module tb_shot_controller;
    import shot_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic frame_clk = 1'b0;
    logic btn = 1'b0;
    logic sbtn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   m_shells = 0, m_score = 0;
    int   sm_shells = 0, sm_score = 0;

    always #5 Clk = ~Clk;

    shot_controller_if bus ();
    shot_controller_if sbus ();

    shot_controller dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .MouseButtons({7'h55, btn}), .bus(bus.slave)
    );

    shot_controller #(.FLASH_FRAMES(1), .COOLDOWN_FRAMES(1), .HIT_POINTS(9)) dut_sat (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .MouseButtons({7'h00, sbtn}), .bus(sbus.slave)
    );

    typedef struct {
        int   cx, cy, dx, dy, sx, sy;
        logic act;
        logic exp_hit;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic model_hit(input int cx, cy, dx, dy, sx, sy, input logic act);
        return act && cx >= dx && cx < dx + sx && cy >= dy && cy < dy + sy;
    endfunction

    function automatic int add_sat(input int s, input int p);
        return (s + p > 9999) ? 9999 : s + p;
    endfunction

    task automatic frame_pulse();
        frame_clk = 1'b1;
        cyc(4);
        frame_clk = 1'b0;
        cyc(4);
    endtask

    task automatic round_start();
        bus.round_start = 1'b1;
        cyc(1);
        bus.round_start = 1'b0;
        cyc(1);
        m_shells = 3;
    endtask

    task automatic set_geom(input int cx, cy, dx, dy, sx, sy, input logic act);
        bus.CursorX = 10'(cx);  bus.CursorY = 10'(cy);
        bus.DogX = 10'(dx);     bus.DogY = 10'(dy);
        bus.DogSizeX = 10'(sx); bus.DogSizeY = 10'(sy);
        bus.dog_active = act;
    endtask

    task automatic click_none(input string tag);
        int pulses;
        pulses = 0;
        btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge Clk); #1;
            if (bus.hit || bus.miss) pulses++;
        end
        btn = 1'b0;
        cyc(4);
        chk({tag, "_no_pulse"}, pulses, 0);
    endtask

    task automatic shoot(input int cx, cy, dx, dy, sx, sy, input logic act,
                         input logic exp_hit, input string tag);
        int   lat, pulses;
        logic got_hit, got_miss;
        set_geom(cx, cy, dx, dy, sx, sy, act);
        lat = -1; pulses = 0; got_hit = 1'b0; got_miss = 1'b0;
        btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge Clk); #1;
            if (bus.hit || bus.miss) begin
                pulses++;
                if (lat < 0) begin
                    lat = i; got_hit = bus.hit; got_miss = bus.miss;
                end
            end
        end
        btn = 1'b0;
        cyc(4);
        m_shells--;
        if (exp_hit) m_score = add_sat(m_score, 5);
        chk({tag, "_latency"}, lat, 5);
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_hit"}, got_hit, exp_hit);
        chk({tag, "_miss"}, got_miss, !exp_hit);
        chk({tag, "_score"}, bus.score_bcd, to_bcd(m_score));
        chk({tag, "_shells"}, bus.shells_left, m_shells);
        chk({tag, "_flash"}, bus.flash, 1);
    endtask

    task automatic finish_shot(input string tag);
        for (int k = 1; k <= 2; k++) begin
            frame_pulse();
            chk({tag, "_flash_frame"}, bus.flash, (k < 2) ? 1 : 0);
        end
        repeat (10) frame_pulse();
        chk({tag, "_state_after"}, bus.state_o, (m_shells > 0) ? 32'(ARMED) : 32'(EMPTY));
    endtask

    initial begin
        int   cx, cy, dx, dy, sx, sy, pulses;
        logic act;
        tbl[0] = '{180, 200, 100, 180, 80, 110, 1'b1, 1'b0};
        tbl[1] = '{100, 180, 100, 180, 80, 110, 1'b1, 1'b1};
        tbl[2] = '{179, 289, 100, 180, 80, 110, 1'b1, 1'b1};
        tbl[3] = '{120, 290, 100, 180, 80, 110, 1'b1, 1'b0};
        tbl[4] = '{ 99, 200, 100, 180, 80, 110, 1'b1, 1'b0};
        tbl[5] = '{120, 200, 100, 180, 80, 110, 1'b0, 1'b0};
        tbl[6] = '{100, 180, 100, 180,  0, 110, 1'b1, 1'b0};
        tbl[7] = '{100, 180, 100, 180, 80,   0, 1'b1, 1'b0};
        tbl[8] = '{1020, 10, 1000,  0, 1000, 50, 1'b1, 1'b1};

        bus.round_start = 1'b0;
        sbus.round_start = 1'b0;
        set_geom(0, 0, 0, 0, 0, 0, 1'b0);
        sbus.CursorX = 10'd50; sbus.CursorY = 10'd50; sbus.DogX = 10'd40; sbus.DogY = 10'd40;
        sbus.DogSizeX = 10'd20; sbus.DogSizeY = 10'd20; sbus.dog_active = 1'b1;

        cyc(3);
        chk("rst_hit", bus.hit, 0);
        chk("rst_miss", bus.miss, 0);
        chk("rst_shells", bus.shells_left, 0);
        chk("rst_score", bus.score_bcd, 16'h0000);
        chk("rst_flash", bus.flash, 0);
        chk("rst_state", bus.state_o, 32'(IDLE));
        Reset_n = 1'b1;
        cyc(2);

        set_geom(120, 200, 100, 180, 80, 110, 1'b1);
        click_none("idle_click");
        chk("idle_state", bus.state_o, 32'(IDLE));

        round_start();
        chk("rs_shells", bus.shells_left, 3);
        chk("rs_score", bus.score_bcd, 16'h0000);
        chk("rs_state", bus.state_o, 32'(ARMED));

        shoot(120, 200, 100, 180, 80, 110, 1'b1, 1'b1, "first");
        click_none("flash_click");
        chk("flash_click_shells", bus.shells_left, m_shells);
        for (int k = 1; k <= 2; k++) begin
            frame_pulse();
            chk("first_flash_frame", bus.flash, (k < 2) ? 1 : 0);
        end
        repeat (9) frame_pulse();
        click_none("cool_click");
        chk("cool_click_shells", bus.shells_left, m_shells);
        chk("cool_state", bus.state_o, 32'(COOLDOWN));
        frame_pulse();
        chk("cool_done_state", bus.state_o, 32'(ARMED));

        for (int v = 0; v < 9; v++) begin
            if (m_shells == 0) round_start();
            shoot(tbl[v].cx, tbl[v].cy, tbl[v].dx, tbl[v].dy, tbl[v].sx, tbl[v].sy,
                  tbl[v].act, tbl[v].exp_hit, $sformatf("vec%0d", v));
            finish_shot($sformatf("vec%0d", v));
        end

        while (m_score < 95) begin
            if (m_shells == 0) round_start();
            shoot(130, 200, 100, 180, 80, 110, 1'b1, 1'b1, "climb");
            finish_shot("climb");
        end
        if (m_shells == 0) round_start();
        shoot(130, 200, 100, 180, 80, 110, 1'b1, 1'b1, "carry");
        chk("carry_0100", bus.score_bcd, 16'h0100);
        finish_shot("carry");

        while (m_shells > 0) begin
            shoot(10, 10, 100, 180, 80, 110, 1'b1, 1'b0, "drain");
            finish_shot("drain");
        end
        chk("empty_state", bus.state_o, 32'(EMPTY));
        set_geom(120, 200, 100, 180, 80, 110, 1'b1);
        click_none("empty_click");
        chk("empty_shells", bus.shells_left, 0);
        round_start();
        chk("reload_shells", bus.shells_left, 3);
        chk("reload_score", bus.score_bcd, to_bcd(m_score));

        for (int r = 0; r < 30; r++) begin
            if (m_shells == 0) round_start();
            dx = int'($urandom_range(0, 900)); dy = int'($urandom_range(0, 900));
            sx = int'($urandom_range(0, 120)); sy = int'($urandom_range(0, 120));
            cx = dx + int'($urandom_range(0, sx + 20)) - 10;
            cy = dy + int'($urandom_range(0, sy + 20)) - 10;
            if (cx < 0) cx = 0;
            if (cy < 0) cy = 0;
            act = ($urandom_range(0, 3) != 0);
            shoot(cx, cy, dx, dy, sx, sy, act, model_hit(cx, cy, dx, dy, sx, sy, act), "rand");
            finish_shot("rand");
        end

        // round_start in the same cycle as the fire pulse: the shot is dropped.
        round_start();
        set_geom(120, 200, 100, 180, 80, 110, 1'b1);
        btn = 1'b1;
        cyc(3);
        bus.round_start = 1'b1;
        cyc(1);
        bus.round_start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.hit || bus.miss) pulses++;
            cyc(1);
        end
        btn = 1'b0;
        cyc(4);
        chk("rs_fire_no_pulse", pulses, 0);
        chk("rs_fire_shells", bus.shells_left, 3);
        chk("rs_fire_state", bus.state_o, 32'(ARMED));

        // round_start during RESOLVE keeps that cycle's hit and score.
        btn = 1'b1;
        cyc(4);
        bus.round_start = 1'b1;
        cyc(1);
        bus.round_start = 1'b0;
        m_score = add_sat(m_score, 5);
        chk("rs_resolve_hit", bus.hit, 1);
        chk("rs_resolve_score", bus.score_bcd, to_bcd(m_score));
        chk("rs_resolve_state", bus.state_o, 32'(ARMED));
        chk("rs_resolve_shells", bus.shells_left, 3);
        chk("rs_resolve_flash", bus.flash, 0);
        cyc(1);
        chk("rs_resolve_hit_drop", bus.hit, 0);
        btn = 1'b0;
        cyc(4);

        shoot(120, 200, 100, 180, 80, 110, 1'b1, 1'b1, "pre_reset");
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_flash", bus.flash, 0);
        chk("async_rst_score", bus.score_bcd, 16'h0000);
        chk("async_rst_state", bus.state_o, 32'(IDLE));
        chk("async_rst_shells", bus.shells_left, 0);
        cyc(2);
        Reset_n = 1'b1;
        cyc(2);

        sm_score = 0;
        sm_shells = 0;
        for (int n = 0; n < 1113; n++) begin
            if (sm_shells == 0) begin
                sbus.round_start = 1'b1;
                cyc(1);
                sbus.round_start = 1'b0;
                cyc(1);
                sm_shells = 3;
            end
            pulses = 0;
            sbtn = 1'b1;
            for (int i = 1; i <= 8; i++) begin
                @(posedge Clk); #1;
                if (sbus.hit) pulses++;
            end
            sbtn = 1'b0;
            cyc(3);
            frame_pulse();
            frame_pulse();
            sm_shells--;
            sm_score = add_sat(sm_score, 9);
            chk("sat_hit", pulses, 1);
            chk("sat_score", sbus.score_bcd, to_bcd(sm_score));
        end
        chk("sat_9999", sbus.score_bcd, 16'h9999);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
